// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: decode issue/hazard query, three writeback requesters
// and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  md_valid;
  logic [ADDR_WIDTH-1:0] md_rd;
  logic [DATA_WIDTH-1:0] md_data;
  logic                  md_ready;
  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport slave (
    input  issue_valid, issue_rd, rs1, rs2,
    input  alu_valid, alu_rd, alu_data,
    input  md_valid, md_rd, md_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output issue_ready, rs1_busy, rs2_busy,
    output alu_ready, md_ready, lsu_ready,
    output rf_we, rf_rd, rf_wdata
  );

  modport master (
    output issue_valid, issue_rd, rs1, rs2,
    output alu_valid, alu_rd, alu_data,
    output md_valid, md_rd, md_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, rs1_busy, rs2_busy,
    input  alu_ready, md_ready, lsu_ready,
    input  rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU, MD and
// LSU writeback, plus the per-register busy scoreboard used for RAW/WAW stalls.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MD  = 2'd1;
  localparam logic [1:0] SRC_LSU = 2'd2;

  logic [1:0]            ptr;
  logic [1:0]            cand;
  logic [1:0]            gsel;
  logic                  gvalid;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] g_rd;
  logic [DATA_WIDTH-1:0] g_data;

  logic                  rf_we_q;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;

  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  issue_ok;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_LSU) ? SRC_ALU : 2'(s + 2'd1);
  endfunction

  function automatic logic has_req(input logic [1:0] s, input logic a, input logic m,
                                   input logic l);
    case (s)
      SRC_ALU: return a;
      SRC_MD:  return m;
      SRC_LSU: return l;
      default: return 1'b0;
    endcase
  endfunction

  // Search ALU, MD, LSU order beginning just after the last grantee.
  always_comb begin
    gvalid = 1'b0;
    gsel   = ptr;
    cand   = next_src(ptr);
    for (int i = 0; i < 3; i++) begin
      if (!gvalid && has_req(cand, bus.alu_valid, bus.md_valid, bus.lsu_valid)) begin
        gvalid = 1'b1;
        gsel   = cand;
      end
      cand = next_src(cand);
    end
  end

  always_comb begin
    g_rd   = bus.alu_rd;
    g_data = bus.alu_data;
    case (gsel)
      SRC_MD:  begin g_rd = bus.md_rd;  g_data = bus.md_data;  end
      SRC_LSU: begin g_rd = bus.lsu_rd; g_data = bus.lsu_data; end
      default: begin g_rd = bus.alu_rd; g_data = bus.alu_data; end
    endcase
  end

  // Grants are suppressed while reset is held so nothing is consumed.
  assign xfer          = gvalid && rst;
  assign bus.alu_ready = xfer && (gsel == SRC_ALU);
  assign bus.md_ready  = xfer && (gsel == SRC_MD);
  assign bus.lsu_ready = xfer && (gsel == SRC_LSU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= SRC_LSU;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else if (xfer) begin
      ptr        <= gsel;
      rf_we_q    <= (g_rd != '0);
      rf_rd_q    <= g_rd;
      rf_wdata_q <= g_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;

  // A register being written this cycle is forwarded, so it reads as free.
  assign bus.rs1_busy    = busy[bus.rs1] && !(rf_we_q && (rf_rd_q == bus.rs1));
  assign bus.rs2_busy    = busy[bus.rs2] && !(rf_we_q && (rf_rd_q == bus.rs2));
  assign issue_ok        = !(busy[bus.issue_rd] && !(rf_we_q && (rf_rd_q == bus.issue_rd)));
  assign bus.issue_ready = issue_ok;

  // Clear on writeback first, then a same-cycle issue to that index re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (rf_we_q) busy_nxt[rf_rd_q] = 1'b0;
    if (bus.issue_valid && issue_ok && (bus.issue_rd != '0)) busy_nxt[bus.issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, output latency,
// scoreboard set/clear and asynchronous reset behaviour.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   md_xfers;

  regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.md_valid && bus.md_ready) md_xfers++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.md_valid  = 1'b0; bus.md_rd  = '0; bus.md_data  = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic test_reset;
    logic [2:0] rdy;
    idle_inputs();
    bus.alu_valid = 1'b1; bus.md_valid = 1'b1; bus.lsu_valid = 1'b1;
    rst = 1'b0;
    #2;
    rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
    total++; if (rdy !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", rdy); end
    tick(); tick();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", bus.rf_we); end
    total++; if (bus.rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d exp=0", bus.rf_rd); end
    total++; if (bus.rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%h exp=0", bus.rf_wdata); end
    idle_inputs();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_basic;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL basic_issue_ready got=%b exp=1", bus.issue_ready); end
    tick();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd5;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL basic_rs1_busy_set got=%b exp=1", bus.rs1_busy); end
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL basic_alu_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL basic_rf_we got=%b exp=1", bus.rf_we); end
    total++; if (bus.rf_rd !== 5'd5) begin bad++; $display("FAIL basic_rf_rd got=%0d exp=5", bus.rf_rd); end
    total++; if (bus.rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rf_wdata got=%h exp=deadbeef", bus.rf_wdata); end
    total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL basic_rs1_fwd got=%b exp=0", bus.rs1_busy); end
    tick();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL basic_rf_we_idle got=%b exp=0", bus.rf_we); end
    total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_cleared got=%b exp=0", bus.rs1_busy); end
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0]  rdy;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd2; bus.md_data  = 32'h22;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
      total++; if (rdy !== exp_rdy[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, rdy, exp_rdy[i]); end
      if (i >= 1) begin
        exp_rd   = 5'(((i - 1) % 3) + 1);
        exp_data = 32'(exp_rd) * 32'h11;
        total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL rr_rf_we[%0d] got=%b exp=1", i, bus.rf_we); end
        total++; if (bus.rf_rd !== exp_rd) begin bad++; $display("FAIL rr_rf_rd[%0d] got=%0d exp=%0d", i, bus.rf_rd, exp_rd); end
        total++; if (bus.rf_wdata !== exp_data) begin bad++; $display("FAIL rr_rf_wdata[%0d] got=%h exp=%h", i, bus.rf_wdata, exp_data); end
      end else begin
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rr_rf_we_first got=%b exp=0", bus.rf_we); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_rd_zero;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL rd0_issue_ready got=%b exp=1", bus.issue_ready); end
    tick();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    #1;
    total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL rd0_rs1_busy got=%b exp=0", bus.rs1_busy); end
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL rd0_alu_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rd0_rf_we got=%b exp=0", bus.rf_we); end
    total++; if (bus.rf_wdata !== 32'h55) begin bad++; $display("FAIL rd0_rf_wdata got=%h exp=55", bus.rf_wdata); end
    tick();
  endtask

  task automatic test_waw;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs2 = 5'd7;
    #1;
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL waw_first_issue got=%b exp=1", bus.issue_ready); end
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    #1;
    total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL waw_stall got=%b exp=0", bus.issue_ready); end
    total++; if (bus.rs2_busy !== 1'b1) begin bad++; $display("FAIL waw_rs2_busy got=%b exp=1", bus.rs2_busy); end
    total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL waw_alu_ready got=%b exp=1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    total++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7) begin bad++; $display("FAIL waw_rf_write got=%b/%0d exp=1/7", bus.rf_we, bus.rf_rd); end
    total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL waw_release got=%b exp=1", bus.issue_ready); end
    total++; if (bus.rs2_busy !== 1'b0) begin bad++; $display("FAIL waw_rs2_fwd got=%b exp=0", bus.rs2_busy); end
    tick();
    bus.issue_valid = 1'b0;
    #1;
    total++; if (bus.rs2_busy !== 1'b1) begin bad++; $display("FAIL waw_set_wins got=%b exp=1", bus.rs2_busy); end
  endtask

  task automatic test_hold;
    logic [2:0] rdy;
    int         base;
    idle_inputs();
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h99;
    #1;
    total++; if (bus.md_ready !== 1'b1) begin bad++; $display("FAIL hold_md_solo got=%b exp=1", bus.md_ready); end
    tick();
    base = md_xfers;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hA0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hB0;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd12; bus.md_data  = 32'hC0;
    #1;
    total++; if (bus.rf_rd !== 5'd9) begin bad++; $display("FAIL hold_md_solo_rd got=%0d exp=9", bus.rf_rd); end
    rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
    total++; if (rdy !== 3'b100) begin bad++; $display("FAIL hold_grant0 got=%b exp=100", rdy); end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
    total++; if (rdy !== 3'b001) begin bad++; $display("FAIL hold_grant1 got=%b exp=001", rdy); end
    total++; if (bus.rf_rd !== 5'd10) begin bad++; $display("FAIL hold_rf_rd1 got=%0d exp=10", bus.rf_rd); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
    total++; if (rdy !== 3'b010) begin bad++; $display("FAIL hold_grant2 got=%b exp=010", rdy); end
    total++; if (bus.rf_rd !== 5'd11) begin bad++; $display("FAIL hold_rf_rd2 got=%0d exp=11", bus.rf_rd); end
    tick();
    bus.md_valid = 1'b0;
    #1;
    total++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd12 || bus.rf_wdata !== 32'hC0) begin
      bad++; $display("FAIL hold_md_write got=%b/%0d/%h exp=1/12/c0", bus.rf_we, bus.rf_rd, bus.rf_wdata);
    end
    total++; if (md_xfers - base !== 1) begin bad++; $display("FAIL hold_md_once got=%0d exp=1", md_xfers - base); end
    tick();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL hold_no_repeat got=%b exp=0", bus.rf_we); end
  endtask

  task automatic test_reset_mid;
    logic [2:0] rdy;
    idle_inputs();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    tick();
    bus.issue_valid = 1'b0; bus.rs1 = 5'd3;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    #1;
    total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL mid_busy3 got=%b exp=1", bus.rs1_busy); end
    tick();
    bus.md_valid = 1'b1; bus.md_rd = 5'd6; bus.md_data = 32'h66;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd8; bus.lsu_data = 32'h88;
    #1;
    total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL mid_rf_we_pre got=%b exp=1", bus.rf_we); end
    rst = 1'b0;
    #1;
    rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL mid_rf_we_rst got=%b exp=0", bus.rf_we); end
    total++; if (rdy !== 3'b000) begin bad++; $display("FAIL mid_ready_rst got=%b exp=000", rdy); end
    tick();
    rst = 1'b1;
    #1;
    rdy = {bus.lsu_ready, bus.md_ready, bus.alu_ready};
    total++; if (rdy !== 3'b001) begin bad++; $display("FAIL mid_first_grant got=%b exp=001", rdy); end
    total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_dropped got=%b exp=0", bus.rs1_busy); end
    idle_inputs();
    tick();
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    md_xfers = 0;
    rst      = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_rd_zero();
    test_waw();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
